// File: rtl/bip_host_link.sv
// bip_host_link: host-side UART end of the BIP link.
// Sends one START_CMD byte on tx_out. Then it receives a 4-byte little-endian
// result on rx_in and presents it as a 32-bit word with a one-cycle done pulse.
// Optional feature: define BIP_HOST_TIMEOUT_EN to build the receive timeout
// (TIMEOUT_TICKS oversample ticks in RECV -> timeout_err, abort to IDLE).
module bip_host_link #(
    parameter int unsigned BAUD_DIV      = 163,
    parameter logic [7:0]  START_CMD     = 8'h53,
    parameter int unsigned TIMEOUT_TICKS = 2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_in,
    output logic        tx_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        frame_err,
    output logic        timeout_err
);

    localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND_CMD, S_RECV} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic [BAUD_W-1:0] baud_cnt;
    logic              tick;

    logic              rx_s1, rx_s2, rx_prev;
    rx_state_t         rx_state;
    logic [3:0]        rx_tick;
    logic [2:0]        rx_bit;
    logic [7:0]        rx_shift;
    logic              rx_valid;
    logic              rx_bad;

    state_t            state;
    logic [8:0]        tx_shift;
    logic [3:0]        tx_tick;
    logic [3:0]        tx_bit;
    logic [1:0]        byte_cnt;
    logic [31:0]       shadow;

`ifdef BIP_HOST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    logic [TO_W-1:0]   to_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    assign tick = (baud_cnt == BAUD_W'(BAUD_DIV - 1));

    // Free-running 16x oversample tick generator
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values;
        // using = here would make results depend on block evaluation order.
        if (reset) begin
            baud_cnt <= '0;
        end else if (tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
        end
    end

    // Two-flop synchronizer for rx_in plus a delayed copy for falling-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx_in;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // 8N1 receiver: arm on falling edge, sample every bit at tick 8, strobe byte or bad stop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_tick  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_bad   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_bad   <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    // A line held low never produces a new edge, so a break reports once
                    if (rx_prev && !rx_s2) begin
                        rx_state <= RX_START;
                        rx_tick  <= '0;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_tick == 4'd7) begin
                            rx_tick  <= '0;
                            rx_bit   <= '0;
                            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tick <= rx_tick + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        if (rx_tick == 4'd15) begin
                            rx_tick  <= '0;
                            rx_shift <= {rx_s2, rx_shift[7:1]};
                            if (rx_bit == 3'd7) begin
                                rx_state <= RX_STOP;
                            end else begin
                                rx_bit <= rx_bit + 3'd1;
                            end
                        end else begin
                            rx_tick <= rx_tick + 4'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (rx_tick == 4'd15) begin
                            rx_tick  <= '0;
                            rx_state <= RX_IDLE;
                            if (rx_s2) begin
                                rx_valid <= 1'b1;
                            end else begin
                                rx_bad <= 1'b1;
                            end
                        end else begin
                            rx_tick <= rx_tick + 4'd1;
                        end
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Link controller: send the command frame, then assemble four reply bytes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            tx_out    <= 1'b1;
            tx_shift  <= '1;
            tx_tick   <= '0;
            tx_bit    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            frame_err <= 1'b0;
            byte_cnt  <= '0;
            // NOTE: the shadow is an ordinary register, so it takes the reset and a
            // partially collected reply can never leak into a later result.
            shadow    <= '0;
`ifdef BIP_HOST_TIMEOUT_EN
            timeout_err <= 1'b0;
            to_cnt      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_SEND_CMD;
                        busy      <= 1'b1;
                        frame_err <= 1'b0;
`ifdef BIP_HOST_TIMEOUT_EN
                        timeout_err <= 1'b0;
`endif
                        tx_out    <= 1'b0;
                        tx_shift  <= {1'b1, START_CMD};
                        tx_tick   <= '0;
                        tx_bit    <= '0;
                    end
                end
                S_SEND_CMD: begin
                    if (tick) begin
                        if (tx_tick == 4'd15) begin
                            tx_tick <= '0;
                            if (tx_bit == 4'd9) begin
                                state    <= S_RECV;
                                byte_cnt <= '0;
`ifdef BIP_HOST_TIMEOUT_EN
                                to_cnt   <= '0;
`endif
                            end else begin
                                tx_out   <= tx_shift[0];
                                tx_shift <= {1'b1, tx_shift[8:1]};
                                tx_bit   <= tx_bit + 4'd1;
                            end
                        end else begin
                            tx_tick <= tx_tick + 4'd1;
                        end
                    end
                end
                S_RECV: begin
                    if (rx_bad) begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (rx_valid) begin
                        shadow[{byte_cnt, 3'b000} +: 8] <= rx_shift;
                        if (byte_cnt == 2'd3) begin
                            result <= {rx_shift, shadow[23:0]};
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
`ifdef BIP_HOST_TIMEOUT_EN
                    else if (tick) begin
                        if (to_cnt == TO_W'(TIMEOUT_TICKS - 1)) begin
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bip_host_link.sv
// Self-checking bench for bip_host_link with BAUD_DIV=4 (64 clk per bit).
// Stimulus pushes expected command bytes and result words into queues;
// independent monitors decode tx_out and watch done, then pop and compare.
`timescale 1ns/1ps
module tb_bip_host_link;

    localparam int         BAUD_DIV = 4;
    localparam int         BIT_CLK  = BAUD_DIV * 16;
    localparam int         TO_TICKS = 100;
    localparam logic [7:0] CMD      = 8'h53;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rx_in = 1'b1;
    logic        tx_out;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        frame_err;
    logic        timeout_err;

    always #5 clk = ~clk;

    bip_host_link #(
        .BAUD_DIV     (BAUD_DIV),
        .START_CMD    (CMD),
        .TIMEOUT_TICKS(TO_TICKS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_in      (rx_in),
        .tx_out     (tx_out),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .frame_err  (frame_err),
        .timeout_err(timeout_err)
    );

    int          checks = 0;
    int          failures = 0;
    int          done_count = 0;
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_res[$];
    logic [31:0] model_result;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reply model of the BIP: one 8N1 byte, LSB first, selectable stop bit
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_in = 1'b0;
        cycles(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            cycles(BIT_CLK);
        end
        rx_in = stop_bit;
        cycles(BIT_CLK);
        rx_in = 1'b1;
        cycles($urandom_range(16, 2));
    endtask

    // Result word goes out least-significant byte first; bad_idx marks a byte with stop=0
    task automatic send_word(input logic [31:0] w, input int bad_idx);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], (i == bad_idx) ? 1'b0 : 1'b1);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    task automatic begin_txn();
        exp_tx.push_back(CMD);
        pulse_start();
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic finish_txn(input logic [31:0] w);
        int c0;
        int n;
        exp_res.push_back(w);
        model_result = w;
        c0 = done_count;
        send_word(w, -1);
        n = 0;
        while (done_count == c0 && n < 200) begin
            cycles(1);
            n++;
        end
        check("done_seen", done_count != c0, 1'b1);
    endtask

    // Done monitor: every done must match the oldest expected result
    initial begin : done_mon
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!reset && done === 1'b1) begin
                done_count++;
                check("done_expected", exp_res.size() != 0, 1'b1);
                if (exp_res.size() != 0) begin
                    e = exp_res.pop_front();
                    check("result", result, e);
                    check("busy_low_at_done", busy, 1'b0);
                end
            end
        end
    end

    // TX monitor: decode frames on tx_out by mid-bit sampling and check bit timing
    initial begin : tx_mon
        logic       prev;
        logic       last;
        logic       aborted;
        logic [9:0] bits;
        int         first_edge;
        bit         timing_ok;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset && prev === 1'b1 && tx_out === 1'b0) begin
                bits       = '0;
                first_edge = -1;
                timing_ok  = 1'b1;
                last       = 1'b0;
                aborted    = 1'b0;
                for (int c = 1; c <= 9 * BIT_CLK + BIT_CLK / 2; c++) begin
                    @(negedge clk);
                    if (reset) aborted = 1'b1;
                    if (tx_out !== last) begin
                        if (first_edge < 0) begin
                            first_edge = c;
                            // start bit is 16 ticks, the first of which may come early
                            if (((c + BAUD_DIV - 1) % BIT_CLK) > BAUD_DIV - 1) timing_ok = 1'b0;
                        end else if (((c - first_edge) % BIT_CLK) != 0) begin
                            timing_ok = 1'b0;
                        end
                        last = tx_out;
                    end
                    if ((c % BIT_CLK) == BIT_CLK / 2) bits[c / BIT_CLK] = tx_out;
                end
                if (!aborted) begin
                    check("tx_frame_expected", exp_tx.size() != 0, 1'b1);
                    if (exp_tx.size() != 0) begin
                        e = exp_tx.pop_front();
                        check("tx_byte", bits[8:1], e);
                        check("tx_start_bit", bits[0], 1'b0);
                        check("tx_stop_bit", bits[9], 1'b1);
                        check("tx_bit_timing", timing_ok, 1'b1);
                    end
                end
            end
            prev = tx_out;
        end
    end

    initial begin : watchdog
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lows;
        int n;
        logic [31:0] w;
        model_result = '0;

        // Reset values
        cycles(5);
        check("rst_tx_out", tx_out, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        reset = 1'b0;
        cycles(5);

        // Basic command/reply, fixed then random words
        begin_txn();
        cycles(700);
        finish_txn(32'h12345678);
        for (int k = 0; k < 2; k++) begin
            begin_txn();
            cycles(700);
            finish_txn($urandom());
        end
        cycles(20);
        check("result_holds", result, model_result);

        // Reset in the middle of the command frame (bit 3 is a 0 bit of 0x53)
        pulse_start();
        cycles(3 * BIT_CLK + BIT_CLK / 2);
        check("tx_mid_frame_low", tx_out, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_tx_out", tx_out, 1'b1);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_result", result, 32'h0);
        model_result = '0;
        cycles(3);
        reset = 1'b0;
        lows = 0;
        repeat (40 * BIT_CLK) begin
            @(negedge clk);
            if (tx_out !== 1'b1) lows++;
        end
        cycles(1);
        check("tx_idle_after_reset", lows, 0);
        check("busy_idle_after_reset", busy, 1'b0);
        check("result_after_reset", result, 32'h0);

        // Give result a known value, then a reply whose third byte has a bad stop bit
        begin_txn();
        cycles(700);
        finish_txn($urandom());
        begin_txn();
        cycles(700);
        send_word($urandom(), 2);
        cycles(10);
        check("frame_err_set", frame_err, 1'b1);
        check("busy_after_frame_err", busy, 1'b0);
        check("result_kept_on_err", result, model_result);
        begin_txn();
        check("frame_err_cleared", frame_err, 1'b0);
        cycles(700);
        finish_txn($urandom());

        // Short glitch on rx_in while receiving, then a proper reply
        begin_txn();
        cycles(700);
        rx_in = 1'b0;
        cycles(3 * BAUD_DIV);
        rx_in = 1'b1;
        cycles(100);
        finish_txn(32'h00FF00FF);

        // Second start while busy is ignored; start on the done cycle is accepted
        begin_txn();
        cycles(10);
        pulse_start();
        check("busy_after_ignored_start", busy, 1'b1);
        cycles(690);
        w = $urandom();
        exp_res.push_back(w);
        model_result = w;
        fork
            send_word(w, -1);
            begin
                n = 0;
                while (done !== 1'b1 && n < 4000) begin
                    cycles(1);
                    n++;
                end
                check("done_for_restart", done, 1'b1);
                exp_tx.push_back(CMD);
                pulse_start();
                check("busy_after_start_on_done", busy, 1'b1);
            end
        join
        cycles(700);
        finish_txn($urandom());

`ifdef BIP_HOST_TIMEOUT_EN
        // No reply: timeout after TO_TICKS ticks in RECV
        begin_txn();
        cycles(1000);
        check("busy_before_timeout", busy, 1'b1);
        check("timeout_not_yet", timeout_err, 1'b0);
        cycles(200);
        check("timeout_err_set", timeout_err, 1'b1);
        check("busy_after_timeout", busy, 1'b0);
        begin_txn();
        check("timeout_err_cleared", timeout_err, 1'b0);
        cycles(700);
        finish_txn($urandom());
`else
        // No reply: without the timeout build the link waits indefinitely
        begin_txn();
        cycles(700 + 1000 * BAUD_DIV + 100);
        check("busy_waits_no_timeout", busy, 1'b1);
        check("timeout_err_tied_low", timeout_err, 1'b0);
        finish_txn($urandom());
`endif

        cycles(700);
        check("tx_queue_drained", exp_tx.size(), 0);
        check("result_queue_drained", exp_res.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
